// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type and default widths for the memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {IDLE, FETCH_WAIT, DATA_WAIT} arb_state_t;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts wait cycles without mem_ack and flags expiry at TIMEOUT-1.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] count;
  // Held at zero outside a wait, so every wait starts counting from zero.
  always_ff @(posedge clk)
    count <= (reset || !active || ack) ? '0 : count + 1'b1;
  assign expired = active && !ack && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-priority (data over fetch) sharing of one memory port.
// Define MEM_TIMEOUT_EN to add the wait-state watchdog that drives bus_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dmem_rd,
  input  logic              dmem_wr,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_ready,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);
  arb_state_t state;
  logic discard;
  logic expired;
  logic done;
`ifdef MEM_TIMEOUT_EN
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) watchdog (
    .clk(clk),
    .reset(reset),
    .active(mem_req),
    .ack(mem_ack),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  assign bus_err = expired;
  assign done = mem_ack || expired;
  assign mem_req = state != IDLE;
  assign dmem_ready = (state == DATA_WAIT) && done;
  // Stores return no data; a timed-out access returns zero.
  assign dmem_rdata = (state == DATA_WAIT && mem_ack && !mem_we) ? mem_rdata : '0;
  assign if_ready = (state == FETCH_WAIT) && done && !discard && !if_abort;
  assign if_rdata = (if_ready && mem_ack) ? mem_rdata : '0;
  assign stall_if = if_req && !if_ready;
  assign stall_mem = (dmem_rd || dmem_wr) && !dmem_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      discard <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_rd || dmem_wr) begin
            state <= DATA_WAIT;
            mem_addr <= dmem_addr;
            mem_we <= dmem_wr;
            mem_wdata <= dmem_wdata;
          end else if (if_req && !if_abort) begin
            state <= FETCH_WAIT;
            mem_addr <= if_addr;
            mem_we <= 1'b0;
          end
        end
        // The memory access always runs to completion; an abort only hides the response.
        FETCH_WAIT: begin
          state <= done ? IDLE : FETCH_WAIT;
          discard <= !done && (discard || if_abort);
        end
        default: state <= done ? IDLE : DATA_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with grant and response scoreboards checked by a monitor.
module tb_mem_port_arbiter;
  logic clk = 0, reset = 1;
  logic if_req = 0, if_abort = 0, dmem_rd = 0, dmem_wr = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dmem_addr = 0, dmem_wdata = 0, mem_rdata = 0;
  logic if_ready, dmem_ready, stall_if, stall_mem, mem_req, mem_we, bus_err;
  logic [31:0] if_rdata, dmem_rdata, mem_addr, mem_wdata;
  typedef struct {logic isData; logic [31:0] data; logic err;} resp_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} grant_t;
  resp_t respQ[$];
  grant_t grantQ[$];
  resp_t expR;
  grant_t cur;
  int tests = 0, fails = 0;
  logic done = 0, rstSeen = 0, prevReq = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) rstSeen <= reset;

  always @(negedge clk) begin
    if (done) begin
      chk("grants_left", grantQ.size(), 0);
      chk("responses_left", respQ.size(), 0);
      chk("final_idle", mem_req, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
    if (rstSeen) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_dmem_ready", dmem_ready, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_stalls", {stall_if, stall_mem}, 0);
    end
    chk("stall_if", stall_if, if_req && !if_ready);
    chk("stall_mem", stall_mem, (dmem_rd || dmem_wr) && !dmem_ready);
    if (!if_ready) chk("if_rdata_idle", if_rdata, 0);
    if (!dmem_ready) chk("dmem_rdata_idle", dmem_rdata, 0);
    if (mem_req && !prevReq) begin
      if (grantQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: got addr %h we %b, expected no grant", mem_addr, mem_we);
      end else begin
        cur = grantQ.pop_front();
        chk("grant_addr", mem_addr, cur.addr);
        chk("grant_we", mem_we, cur.we);
        if (cur.we) chk("grant_wdata", mem_wdata, cur.wdata);
      end
    end else if (mem_req) begin
      chk("hold_addr", mem_addr, cur.addr);
      chk("hold_we", mem_we, cur.we);
    end
    prevReq = mem_req;
    if (if_ready || dmem_ready || bus_err) begin
      if (respQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_response: got if_ready=%b dmem_ready=%b bus_err=%b, expected none",
                 if_ready, dmem_ready, bus_err);
      end else begin
        expR = respQ.pop_front();
        chk("owner_if_ready", if_ready, !expR.isData);
        chk("owner_dmem_ready", dmem_ready, expR.isData);
        chk("rdata", expR.isData ? dmem_rdata : if_rdata, expR.data);
        chk("bus_err", bus_err, expR.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input int n, input logic [31:0] d);
    repeat (n - 1) tick();
    mem_ack = 1;
    mem_rdata = d;
    tick();
    mem_ack = 0;
    mem_rdata = 0;
  endtask

  task automatic expGrant(input logic [31:0] a, input logic w, input logic [31:0] d);
    grant_t g;
    g.addr = a;
    g.we = w;
    g.wdata = d;
    grantQ.push_back(g);
  endtask

  task automatic expResp(input logic isData, input logic [31:0] d, input logic err);
    resp_t r;
    r.isData = isData;
    r.data = d;
    r.err = err;
    respQ.push_back(r);
  endtask

  initial begin
    repeat (2) tick();
    reset = 0;
    tick();
    // Fetch only, ack in the third wait cycle.
    if_req = 1;
    if_addr = 32'h0040_0000;
    expGrant(32'h0040_0000, 0, 0);
    expResp(0, 32'h2002_0005, 0);
    tick();
    ack(3, 32'h2002_0005);
    if_req = 0;
    tick();
    // Collision: data first, then fetch in the following idle cycle.
    if_req = 1;
    if_addr = 32'h0040_0004;
    dmem_rd = 1;
    dmem_addr = 32'h1001_0000;
    expGrant(32'h1001_0000, 0, 0);
    expGrant(32'h0040_0004, 0, 0);
    expResp(1, 32'h1111_2222, 0);
    expResp(0, 32'h3333_4444, 0);
    tick();
    ack(1, 32'h1111_2222);
    dmem_rd = 0;
    tick();
    ack(2, 32'h3333_4444);
    if_req = 0;
    tick();
    // Store.
    dmem_wr = 1;
    dmem_addr = 32'h1001_0004;
    dmem_wdata = 32'hCAFE_F00D;
    expGrant(32'h1001_0004, 1, 32'hCAFE_F00D);
    expResp(1, 32'h0, 0);
    tick();
    ack(4, 32'h0);
    dmem_wr = 0;
    tick();
    // Abort mid-wait, then the redirected fetch.
    if_req = 1;
    if_addr = 32'h0040_0008;
    expGrant(32'h0040_0008, 0, 0);
    tick();
    tick();
    if_abort = 1;
    tick();
    if_abort = 0;
    if_addr = 32'h0040_0100;
    tick();
    mem_ack = 1;
    mem_rdata = 32'h9999_9999;
    tick();
    mem_ack = 0;
    mem_rdata = 0;
    expGrant(32'h0040_0100, 0, 0);
    expResp(0, 32'h2402_0001, 0);
    tick();
    ack(1, 32'h2402_0001);
    if_req = 0;
    tick();
    // Abort in the ack cycle suppresses the response.
    if_req = 1;
    if_addr = 32'h0040_000C;
    expGrant(32'h0040_000C, 0, 0);
    tick();
    if_abort = 1;
    ack(1, 32'h5555_5555);
    if_abort = 0;
    if_req = 0;
    tick();
    // Abort while idle blocks the grant that cycle.
    if_req = 1;
    if_abort = 1;
    tick();
    if_req = 0;
    if_abort = 0;
    tick();
    // Reset mid data wait, then a stale ack in idle.
    dmem_rd = 1;
    dmem_addr = 32'h1001_0008;
    expGrant(32'h1001_0008, 0, 0);
    tick();
    tick();
    reset = 1;
    dmem_rd = 0;
    tick();
    reset = 0;
    mem_ack = 1;
    mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 0;
    mem_rdata = 0;
    tick();
`ifdef MEM_TIMEOUT_EN
    // No ack: timeout in wait cycle 16.
    dmem_rd = 1;
    dmem_addr = 32'h1001_000C;
    expGrant(32'h1001_000C, 0, 0);
    expResp(1, 32'h0, 1);
    tick();
    repeat (16) tick();
    dmem_rd = 0;
    tick();
    tick();
`endif
    done = 1;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline. Fixed priority: data beats fetch, because the older instruction must complete first. Drives stall signals back to the pipeline and supports discarding an in-flight fetch when the hazard unit redirects the PC. Sits between the pipeline stages and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
TIMEOUT, 16, cycles in a wait state before a timeout (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held until if_ready or if_abort
if_addr  input  ADDR_W  fetch address (PC)
if_abort  input  1  discard the current/pending fetch (branch taken or jump)
if_ready  output  1  fetch complete; if_rdata valid this cycle
if_rdata  output  DATA_W  fetched instruction
dmem_rd  input  1  load request
dmem_wr  input  1  store request
dmem_addr  input  ADDR_W  data address
dmem_wdata  input  DATA_W  store data
dmem_ready  output  1  data access complete; dmem_rdata valid this cycle for loads
dmem_rdata  output  DATA_W  load data
stall_if  output  1  if_req && !if_ready
stall_mem  output  1  (dmem_rd||dmem_wr) && !dmem_ready
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  write enable
mem_addr  output  ADDR_W  registered address
mem_wdata  output  DATA_W  registered write data
mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1
mem_ack  input  1  one-cycle completion pulse
bus_err  output  1  one-cycle timeout pulse

Behaviour:
- States: IDLE, FETCH_WAIT, DATA_WAIT.
- Reset value of every output is 0. On reset: state goes to IDLE, the discard flag clears, mem_req drops immediately, and any in-flight transaction is abandoned.
- IDLE:
  - If dmem_rd or dmem_wr is asserted: latch dmem_addr, dmem_wdata and mem_we=dmem_wr; go to DATA_WAIT.
  - Else if if_req && !if_abort: latch if_addr with mem_we=0; go to FETCH_WAIT.
  - Else stay in IDLE.
- Simultaneous fetch and data requests: data always wins. The fetch keeps stalling.
- mem_req = (state != IDLE). mem_addr, mem_we and mem_wdata come from registers and are stable for the whole wait.
- DATA_WAIT: on mem_ack, assert dmem_ready combinationally in the same cycle, pass mem_rdata through to dmem_rdata, and go to IDLE.
- FETCH_WAIT:
  - if_abort in any cycle (including the ack cycle) sets a discard flag.
  - On mem_ack: if_ready = !discard && !if_abort, if_rdata = mem_rdata; clear discard; go to IDLE.
  - The memory transaction is never cut short; only the response is suppressed.
- if_abort while in IDLE has no state effect.
- Requesters update or drop their request at the clock edge after ready. The arbiter never re-grants in the ack cycle.
- Latency: minimum 2 cycles from request to ready (mem_ack in the first wait cycle). Back-to-back accesses cost 2 cycles each.
- Starvation: fetch may be delayed indefinitely by consecutive data requests. This is acceptable because each data request retires an instruction.
- if_rdata and dmem_rdata are 0 outside their ready cycles.
- A mem_ack arriving in IDLE is ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to a wait state and increments each cycle without mem_ack.
  - When the count reaches TIMEOUT-1 without ack: pulse bus_err for 1 cycle, drop mem_req, go to IDLE.
  - In the same cycle, assert the owner's ready with rdata=0. A discarded fetch gets no ready.
- Undefined: the arbiter waits forever and bus_err is tied 0.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, FETCH_WAIT, DATA_WAIT}
  - the default width constants
- Optional sub-module mem_arb_watchdog (counter plus expiry flag), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x0040_0000, mem_ack 3 cycles after mem_req rises, mem_rdata=0x2002_0005 -> if_ready pulses once with if_rdata=0x2002_0005; stall_if=1 until then.
2. Collision: if_req and dmem_rd (addr 0x1001_0000) asserted in the same IDLE cycle -> DATA_WAIT first, mem_addr=0x1001_0000; fetch granted in the IDLE cycle following dmem_ready.
3. Store: dmem_wr=1, wdata=0xCAFE_F00D -> mem_we=1, mem_wdata=0xCAFE_F00D held until ack; dmem_ready=1 and dmem_rdata=0 in the ack cycle.
4. Abort: if_abort pulses 1 cycle into FETCH_WAIT, ack 2 cycles later -> no if_ready; the next fetch to the new PC is granted afterwards.
5. Reset mid-DATA_WAIT -> mem_req=0 the next cycle, state IDLE, all outputs 0; the late mem_ack is ignored.
6. With MEM_TIMEOUT_EN and TIMEOUT=16, mem_ack never arrives -> bus_err and dmem_ready pulse in wait cycle 16 with rdata=0; back in IDLE afterwards.
